// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared encodings for the multi-cycle RV32I control path
package rv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } state_t;

  typedef enum logic [2:0] {
    CL_ALU,
    CL_LOAD,
    CL_STORE,
    CL_BRANCH,
    CL_JAL,
    CL_JALR
  } iclass_t;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JALR   = 2'd2;
  localparam logic [1:0] PC_JAL    = 2'd3;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;
  localparam logic [1:0] WB_IMM  = 2'd3;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

endpackage

// File: rtl/rv_decode.sv
// rtl/rv_decode.sv - combinational IR field decode into instruction class and datapath selects
module rv_decode
  import rv_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output iclass_t    iclass,
  output logic [3:0] alu_sel,
  output logic       rs2_imm_sel,
  output logic [1:0] wb_sel,
  output logic       illegal
);

  logic bit30;
  assign bit30 = funct7[5];

  always_comb begin
    iclass      = CL_ALU;
    alu_sel     = ALU_ADD;
    rs2_imm_sel = 1'b1;
    wb_sel      = WB_ALU;
    illegal     = 1'b0;
    case (opcode)
      OPC_OP: begin
        rs2_imm_sel = 1'b0;
        alu_sel     = {funct3, bit30};
        // only ADD/SUB and SRL/SRA have an alternate funct7 encoding
        illegal = !((funct7 == 7'h00) ||
                    ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OPC_OP_IMM: begin
        if (funct3 == 3'b001) begin
          alu_sel = {funct3, 1'b0};
          illegal = (funct7 != 7'h00);
        end else if (funct3 == 3'b101) begin
          alu_sel = {funct3, bit30};
          illegal = !((funct7 == 7'h00) || (funct7 == 7'h20));
        end else begin
          alu_sel = {funct3, 1'b0};
        end
      end
      OPC_LOAD: begin
        iclass  = CL_LOAD;
        wb_sel  = WB_LOAD;
        illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        iclass  = CL_STORE;
        illegal = funct3[2] || (funct3 == 3'b011);
      end
      OPC_BRANCH: begin
        iclass      = CL_BRANCH;
        rs2_imm_sel = 1'b0;
        alu_sel     = ALU_SUB;
        illegal     = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OPC_JAL: begin
        iclass = CL_JAL;
        wb_sel = WB_PC4;
      end
      OPC_JALR: begin
        iclass  = CL_JALR;
        wb_sel  = WB_PC4;
        illegal = (funct3 != 3'b000);
      end
      OPC_LUI:   wb_sel = WB_IMM;
      OPC_AUIPC: wb_sel = WB_ALU;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// rtl/rv_multicycle_ctrl.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM with
// memory handshake, timeout and illegal-instruction traps, and retired-instruction counter
module rv_multicycle_ctrl
  import rv_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr_in,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic [1:0]       mem_size,
  output logic             mem_unsigned,
  output logic             ir_wenb,
  output logic             pc_wenb,
  output logic [1:0]       pc_sel,
  output logic             rf_wenb,
  output logic [1:0]       wb_sel,
  output logic [3:0]       alu_sel,
  output logic             rs2_imm_sel,
  output logic [CNT_W-1:0] instret,
  output logic             trap,
  output logic [1:0]       trap_cause
);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state, state_next;
  logic [31:0]       ir;
  logic [WAIT_W-1:0] wait_cnt;
  logic [1:0]        cause_next;
  logic              retire;
  logic              mem_phase;
  logic              timeout;

  iclass_t    iclass;
  logic [3:0] dec_alu_sel;
  logic       dec_rs2_imm_sel;
  logic [1:0] dec_wb_sel;
  logic       dec_illegal;

  // rs1/rs2/immediate fields belong to the datapath, not to control
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir[24:15];

  rv_decode u_decode (
    .opcode      (ir[6:0]),
    .funct3      (ir[14:12]),
    .funct7      (ir[31:25]),
    .iclass      (iclass),
    .alu_sel     (dec_alu_sel),
    .rs2_imm_sel (dec_rs2_imm_sel),
    .wb_sel      (dec_wb_sel),
    .illegal     (dec_illegal)
  );

  assign mem_phase = (state == ST_FETCH) || (state == ST_MEM);
  // a response in the last allowed cycle still wins over the trap
  assign timeout   = mem_phase && !mem_ready && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_FETCH;
      ir         <= 32'h0;
      wait_cnt   <= '0;
      instret    <= '0;
      trap_cause <= CAUSE_NONE;
    end else begin
      state      <= state_next;
      trap_cause <= cause_next;
      if (ir_wenb) ir <= instr_in;
      if (retire) instret <= instret + CNT_W'(1);
      if ((state_next != state) || mem_ready) wait_cnt <= '0;
      else if (mem_phase) wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  always_comb begin
    state_next   = state;
    cause_next   = trap_cause;
    retire       = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    mem_size     = 2'd0;
    mem_unsigned = 1'b0;
    ir_wenb      = 1'b0;
    pc_wenb      = 1'b0;
    pc_sel       = PC_PLUS4;
    rf_wenb      = 1'b0;
    wb_sel       = WB_ALU;
    alu_sel      = ALU_ADD;
    rs2_imm_sel  = 1'b0;
    trap         = 1'b0;
    if (!rst) begin
      if ((state == ST_EXEC) || (state == ST_MEM) || (state == ST_WB)) begin
        alu_sel     = dec_alu_sel;
        rs2_imm_sel = dec_rs2_imm_sel;
        wb_sel      = dec_wb_sel;
      end
      case (state)
        ST_FETCH: begin
          mem_req  = 1'b1;
          mem_size = 2'd2;
          if (mem_ready) begin
            ir_wenb    = 1'b1;
            state_next = ST_DECODE;
          end else if (timeout) begin
            state_next = ST_TRAP;
            cause_next = CAUSE_TIMEOUT;
          end
        end
        ST_DECODE: begin
          if (dec_illegal) begin
            state_next = ST_TRAP;
            cause_next = CAUSE_ILLEGAL;
          end else begin
            state_next = ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (iclass)
            CL_LOAD, CL_STORE: state_next = ST_MEM;
            CL_BRANCH: begin
              pc_wenb    = 1'b1;
              pc_sel     = branch_taken ? PC_BRANCH : PC_PLUS4;
              retire     = 1'b1;
              state_next = ST_FETCH;
            end
            default: state_next = ST_WB;
          endcase
        end
        ST_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = (iclass == CL_STORE);
          mem_size     = ir[13:12];
          mem_unsigned = ir[14] && (iclass == CL_LOAD);
          if (mem_ready) begin
            if (iclass == CL_STORE) begin
              pc_wenb    = 1'b1;
              retire     = 1'b1;
              state_next = ST_FETCH;
            end else begin
              state_next = ST_WB;
            end
          end else if (timeout) begin
            state_next = ST_TRAP;
            cause_next = CAUSE_TIMEOUT;
          end
        end
        ST_WB: begin
          rf_wenb = (ir[11:7] != 5'd0);
          pc_wenb = 1'b1;
          if (iclass == CL_JAL) pc_sel = PC_JAL;
          else if (iclass == CL_JALR) pc_sel = PC_JALR;
          retire     = 1'b1;
          state_next = ST_FETCH;
        end
        ST_TRAP: trap = 1'b1;
        default: state_next = ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// tb/tb_rv_multicycle_ctrl.sv - directed self-checking bench for rv_multicycle_ctrl
module tb_rv_multicycle_ctrl;

  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_LW   = 32'h0000A103;
  localparam logic [31:0] I_BEQ  = 32'h00000463;
  localparam logic [31:0] I_JAL  = 32'h000000EF;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;

  logic        clk;
  logic        rst;
  logic [31:0] instr_in;
  logic        mem_ready;
  logic        branch_taken;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic        ir_wenb;
  logic        pc_wenb;
  logic [1:0]  pc_sel;
  logic        rf_wenb;
  logic [1:0]  wb_sel;
  logic [3:0]  alu_sel;
  logic        rs2_imm_sel;
  logic [31:0] instret;
  logic        trap;
  logic [1:0]  trap_cause;

  int tests;
  int fails;

  rv_multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_in     (instr_in),
    .mem_ready    (mem_ready),
    .branch_taken (branch_taken),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .mem_size     (mem_size),
    .mem_unsigned (mem_unsigned),
    .ir_wenb      (ir_wenb),
    .pc_wenb      (pc_wenb),
    .pc_sel       (pc_sel),
    .rf_wenb      (rf_wenb),
    .wb_sel       (wb_sel),
    .alu_sel      (alu_sel),
    .rs2_imm_sel  (rs2_imm_sel),
    .instret      (instret),
    .trap         (trap),
    .trap_cause   (trap_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    instr_in = 32'h0;
    mem_ready = 1'b0;
    branch_taken = 1'b0;

    smp();
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_strobes", {27'd0, mem_we, ir_wenb, pc_wenb, rf_wenb, trap}, 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_cause", {30'd0, trap_cause}, 32'd0);

    // addi x1,x0,5 : F D E W
    cyc(); rst = 1'b0; instr_in = I_ADDI; mem_ready = 1'b1;
    smp();
    chk("addi_f_req", {29'd0, mem_req, mem_addr_sel, ir_wenb}, 32'b101);
    chk("addi_f_size", {30'd0, mem_size}, 32'd2);
    cyc(); smp();
    chk("addi_d_quiet", {28'd0, mem_req, ir_wenb, pc_wenb, rf_wenb}, 32'd0);
    cyc(); smp();
    chk("addi_e_alu", {27'd0, alu_sel, rs2_imm_sel}, {27'd0, 4'b0000, 1'b1});
    chk("addi_e_rf", {31'd0, rf_wenb}, 32'd0);
    cyc(); smp();
    chk("addi_w_en", {28'd0, rf_wenb, pc_wenb, pc_sel}, {28'd0, 2'b11, 2'd0});
    chk("addi_w_sel", {30'd0, wb_sel}, 32'd0);

    // lw x2,0(x1) with three wait cycles in MEM
    cyc(); instr_in = I_LW; mem_ready = 1'b1;
    smp();
    chk("addi_instret", instret, 32'd1);
    chk("lw_f_rf_off", {30'd0, rf_wenb, ir_wenb}, 32'b01);
    cyc(); cyc(); mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(); smp();
      chk("lw_m_wait", {28'd0, mem_req, mem_addr_sel, mem_we, mem_unsigned}, 32'b1100);
    end
    cyc(); mem_ready = 1'b1; smp();
    chk("lw_m_done", {29'd0, mem_req, mem_addr_sel, pc_wenb}, 32'b110);
    chk("lw_m_size", {30'd0, mem_size}, 32'd2);
    cyc(); smp();
    chk("lw_w", {29'd0, rf_wenb, wb_sel}, {29'd0, 1'b1, 2'd1});

    // beq taken then not taken
    cyc(); instr_in = I_BEQ; smp();
    chk("lw_instret", instret, 32'd2);
    cyc(); cyc(); branch_taken = 1'b1; smp();
    chk("beq_t_pc", {28'd0, pc_wenb, rf_wenb, pc_sel}, {28'd0, 2'b10, 2'd1});
    chk("beq_t_alu", {27'd0, alu_sel, rs2_imm_sel}, {27'd0, 4'b1000, 1'b0});
    cyc(); smp();
    chk("beq_t_instret", instret, 32'd3);
    cyc(); cyc(); branch_taken = 1'b0; smp();
    chk("beq_nt_pc", {28'd0, pc_wenb, rf_wenb, pc_sel}, {28'd0, 2'b10, 2'd0});

    // fetch of jal answered on the 4th cycle: limit reached but ready wins
    cyc(); instr_in = I_JAL; mem_ready = 1'b0; smp();
    chk("beq_nt_instret", instret, 32'd4);
    cyc(); cyc(); smp();
    chk("late_w3", {30'd0, mem_req, trap}, 32'b10);
    cyc(); mem_ready = 1'b1; smp();
    chk("late_w4", {29'd0, ir_wenb, trap, mem_req}, 32'b101);
    cyc(); cyc(); cyc(); smp();
    chk("jal_w", {27'd0, rf_wenb, pc_sel, wb_sel}, {27'd0, 1'b1, 2'd3, 2'd2});

    // fetch with no response: trap after 4 wait cycles
    cyc(); mem_ready = 1'b0; smp();
    chk("jal_instret", instret, 32'd5);
    cyc(); cyc(); cyc(); smp();
    chk("to_w4", {30'd0, mem_req, trap}, 32'b10);
    cyc(); smp();
    chk("to_trap", {29'd0, trap, trap_cause}, {29'd0, 1'b1, 2'd2});
    chk("to_quiet", {31'd0, mem_req}, 32'd0);
    chk("to_instret", instret, 32'd5);

    cyc(); rst = 1'b1; #1;
    chk("rst_clear_trap", {29'd0, trap, trap_cause}, 32'd0);

    // full store
    cyc(); rst = 1'b0; instr_in = I_SW; mem_ready = 1'b1; smp();
    chk("rst_instret0", instret, 32'd0);
    cyc(); cyc(); cyc(); smp();
    chk("sw_m", {27'd0, mem_req, mem_we, mem_addr_sel, pc_wenb, rf_wenb}, 32'b11110);
    chk("sw_m_pcsel", {30'd0, pc_sel}, 32'd0);

    // illegal instruction
    cyc(); instr_in = I_BAD; smp();
    chk("sw_instret", instret, 32'd1);
    cyc(); smp();
    chk("bad_d", {31'd0, trap}, 32'd0);
    cyc(); smp();
    chk("bad_trap", {29'd0, trap, trap_cause}, {29'd0, 1'b1, 2'd1});
    for (int i = 0; i < 20; i++) begin
      cyc(); mem_ready = i[0]; smp();
      chk("bad_hold", {26'd0, mem_req, mem_we, ir_wenb, pc_wenb, rf_wenb, trap}, 32'b1);
    end
    chk("bad_instret", instret, 32'd1);
    chk("bad_cause", {30'd0, trap_cause}, 32'd1);

    // store stalled in MEM, reset asserted mid-cycle
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0; instr_in = I_SW; mem_ready = 1'b1;
    cyc(); cyc(); cyc(); mem_ready = 1'b0; smp();
    chk("sw2_m", {29'd0, mem_req, mem_we, mem_addr_sel}, 32'b111);
    rst = 1'b1; #1;
    chk("async_rst", {28'd0, mem_req, mem_we, mem_addr_sel, pc_wenb}, 32'd0);
    cyc(); rst = 1'b0; smp();
    chk("post_rst_fetch", {30'd0, mem_req, mem_addr_sel}, 32'b10);
    chk("post_rst_instret", instret, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rv_multicycle_ctrl.md
Name: rv_multicycle_ctrl

Overview:
- Sequential successor to the single-cycle RV32I decoder: a multi-cycle control FSM that sequences FETCH/DECODE/EXEC/MEM/WB.
- Drives datapath enables one state at a time and handshakes with a shared instruction/data memory through req/ready.
- Adds what the combinational decoder lacks: variable memory latency, a timeout trap, illegal-instruction trap and a retired-instruction counter.
- Sits between the memory port and the existing ALU/register-file/PC datapath.

Parameters:
- MEM_TIMEOUT, 16, maximum cycles to wait for mem_ready before trapping (>=1).
- CNT_W, 32, width of instret counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- instr_in  in  32  memory read data, valid when mem_ready=1 in FETCH
- mem_ready  in  1  memory completes the current request
- branch_taken  in  1  comparator result for the latched branch
- mem_req  out  1  memory request
- mem_we  out  1  store write strobe, only with mem_req
- mem_addr_sel  out  1  0=PC, 1=ALU result
- mem_size  out  2  0=byte, 1=half, 2=word (IR funct3[1:0])
- mem_unsigned  out  1  IR funct3[2] for loads
- ir_wenb  out  1  latch instr_in into IR
- pc_wenb  out  1  update PC
- pc_sel  out  2  0=PC+4, 1=branch target, 2=JALR target, 3=JAL target
- rf_wenb  out  1  register-file write
- wb_sel  out  2  0=ALU, 1=load data, 2=PC+4, 3=imm (LUI)
- alu_sel  out  4  ALU operation
- rs2_imm_sel  out  1  1=immediate operand
- instret  out  CNT_W  retired-instruction count
- trap  out  1  core halted
- trap_cause  out  2  0=none, 1=illegal, 2=memory timeout

Behaviour:
- Reset: state=FETCH, IR=0, instret=0, trap=0, trap_cause=0, wait counter=0. Every strobe is 0 while rst is high. Reset takes effect immediately in any state, including mid-MEM; the outstanding request is dropped.
- FETCH: mem_req=1, mem_addr_sel=0, mem_size=2. On mem_ready: ir_wenb=1, go to DECODE.
- DECODE: decode IR (opcode, funct3, bit30). An unsupported opcode/funct3/funct7 combination goes to TRAP with cause 1. Otherwise go to EXEC. No strobes.
- EXEC:
  - R/I/LUI/AUIPC/JAL/JALR go to WB.
  - Loads and stores go to MEM.
  - Branch: pc_wenb=1, pc_sel=branch_taken?1:0, instret+1, go to FETCH.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=store. On mem_ready, a load goes to WB; a store sets pc_wenb=1, pc_sel=0, instret+1 and goes to FETCH.
- WB:
  - rf_wenb=1, suppressed when rd=0.
  - pc_wenb=1; pc_sel=3 for JAL, 2 for JALR, otherwise 0.
  - instret+1, go to FETCH.
- TRAP: all strobes 0, trap=1, trap_cause held. Leaves only on reset.
- Latency with mem_ready=1 on first cycle: ALU ops 4 cycles, branch 3, store 4, load 5. Each wait cycle adds 1.
- Timeout:
  - The wait counter increments each FETCH/MEM cycle that has mem_req=1 and mem_ready=0.
  - It clears on mem_ready or on any state change.
  - Reaching MEM_TIMEOUT goes to TRAP with cause 2 on the next edge.
  - mem_ready arriving in the same cycle the count reaches the limit wins (no trap).
- alu_sel:
  - {funct3, bit30} for R-type.
  - {funct3, bit30} for SRLI/SRAI; {funct3, 0} for all other OP-IMM.
  - 4'b0000 (add) for load/store/AUIPC/JALR/JAL.
  - 4'b1000 (sub) for branches.
- rs2_imm_sel=1 for all non-R, non-branch instructions.
- Outputs are Moore decodes of state+IR, except ir_wenb/pc_wenb/instret update, which also qualify on mem_ready/branch_taken in the same cycle.
- instret wraps modulo 2^CNT_W.

Decomposition:
- Shared package rv_pkg holds:
  - opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC)
  - state enum
  - pc_sel, wb_sel and trap_cause encodings
  - ALU op encodings
- One sub-module, rv_decode: purely combinational IR to {class, alu_sel, rs2_imm_sel, wb_sel, illegal}. The FSM, wait counter and instret stay in the top level.

Test Plan:
- addi x1,x0,5 (0x00500093), mem_ready always 1 -> states F,D,E,W in 4 cycles; rf_wenb for exactly 1 cycle; alu_sel=0000, rs2_imm_sel=1; instret=1.
- lw x2,0(x1) (0x0000A103), data mem_ready delayed 3 cycles -> mem_req/mem_addr_sel=1 held 4 cycles, mem_size=2, wb_sel=1, total 8 cycles, instret=1.
- beq x0,x0,+8 (0x00000463) with branch_taken=1 -> pc_wenb with pc_sel=1 in EXEC, no rf_wenb, 3 cycles; repeat with branch_taken=0 -> pc_sel=0.
- Fetch of 0xFFFFFFFF -> TRAP after DECODE; trap=1, trap_cause=1, all strobes 0 for 20 further cycles; instret unchanged.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> trap_cause=2 after 4 wait cycles. Second run: mem_ready on the 4th cycle -> no trap.
- sw in MEM with mem_ready=0, rst pulsed mid-cycle -> outputs 0 asynchronously; after release, state=FETCH and instret=0.
